reg_trace_monitor: RTL and testbench
====================================

// Module: reg_trace_monitor
// PURPOSE
//  Synthesizable successor to the bench-side register trace. Watches NCH WIDTH-bit
//  probe channels (e.g. regfile entries $t0/$t1). Every change is logged as a
//  {timestamp, channel, value} event in a DEPTH-entry FIFO, read out through a
//  valid/ready port. Sits beside mips_system; readout goes to the sw/led debug path or a host.
// PARAMETERS
//  NCH    2   number of probed channels (1..16)
//  WIDTH  32  bits per channel
//  DEPTH  16  event FIFO entries (power of 2, >=2)
//  TS_W   16  free-running timestamp width
// PORTS
//  clk        in   1             system clock, single domain
//  rst        in   1             asynchronous reset, active-low
//  en         in   1             trace enable
//  ch_data    in   NCH*WIDTH     probes; channel k = ch_data[k*WIDTH +: WIDTH]
//  ch_mask    in   NCH           per-channel enable; present only with TRACE_FILTER_EN
//  out_valid  out  1             FIFO head holds an event
//  out_ready  in   1             consumer accepts head
//  out_ts     out  TS_W          timestamp of head event
//  out_ch     out  clog2(NCH)+1  channel index of head event
//  out_data   out  WIDTH         captured value of head event
//  count      out  clog2(DEPTH)+1 entries in FIFO
//  lost       out  1             sticky: some event was overwritten before it was queued
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, out_valid=0, out_* =0, count=0,
//    lost=0, ts=0, all pending=0, baseline armed=0.
//  - ts increments every cycle en=1 and wraps 2^TS_W-1 -> 0. Holds when en=0.
//  - Cycle en goes 0->1: snapshot all channels as baseline. No events, armed=1.
//  - en=1 and armed: channel k whose ch_data differs from its last sample raises an event.
//    prev[k], pending[k]=1, cap_val[k]=new value and cap_ts[k]=ts are all set in that cycle.
//    Event on an already-pending channel overwrites cap_val/cap_ts and sets lost=1.
//  - Arbiter: each cycle pushes the lowest-index pending channel. Push happens if
//    !full or pop in the same cycle. The pushed channel's pending clears. One push per cycle.
//    Pending clear and a new change on the same channel in one cycle: new change wins,
//    pending stays 1.
//  - Event latency: change at cycle N -> entry at FIFO head/out_valid at N+2 if FIFO empty.
//  - Pop when out_valid && out_ready. Head is registered. out_* stable while out_valid && !out_ready.
//  - Full and no pop: pending accumulate (at most one per channel). FIFO never overwritten.
//  - en=0: no new events, armed=0. Pending entries keep draining. Readout continues.
//  - lost is cleared only by reset.
// CONFIGURATION
//  TRACE_FILTER_EN defined: ch_mask port exists. Channel k with ch_mask[k]=0 still updates
//    prev but raises no event. Its existing pending entry still drains.
//  TRACE_FILTER_EN undefined: no ch_mask port. All channels are traced.
// STRUCTURE
//  - trace_pkg: event field widths, CH_W/CNT_W clog2 helper function, event pack/unpack macros.
//  - Sub-module trace_fifo (DEPTH x (TS_W+CH_W+WIDTH)).
//    Interface: wr_en/wr_data/full, rd_en/rd_data/empty/count.
//    Same async active-low rst. Registered read head.
//  - Top: change detect, pending/capture regs, priority arbiter, ts counter.
// TESTING
//  1 Reset: rst=0 mid-traffic with 5 entries queued -> next cycle out_valid=0, count=0,
//    lost=0. After release, en=1 gives no event for the unchanged baseline.
//  2 Single change: ch0 0->0x2A at ts=3 -> two cycles later out_valid=1,
//    out_ch=0, out_data=0x2A, out_ts=3. out_ready=1 -> count 1->0.
//  3 Simultaneous: ch0->7, ch1->9 in same cycle -> ch0 entry then ch1 entry on
//    consecutive cycles, both with identical out_ts.
//  4 Full/backpressure: DEPTH=4, out_ready=0, 6 changes alternating ch0/ch1 ->
//    count=4, pending held. Second change to a pending ch sets lost=1.
//    out_ready=1 -> remaining events drain in order.
//  5 Wrap: TS_W=4, change at cycles 15 and 17 after arm -> out_ts 15 then 1.
//  6 TRACE_FILTER_EN, ch_mask=2'b10: ch0 and ch1 both change -> only ch1 event logged.
//    Unmask ch0 with no further change -> no event.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types, width helpers and event pack/unpack macros for the register trace monitor.
`ifndef TRACE_PKG_SV
`define TRACE_PKG_SV

`define TRACE_EV_PACK(ts, ch, d) {(ts), (ch), (d)}
`define TRACE_EV_FIELDS(ts, ch, d) {ts, ch, d}

package trace_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } trace_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ch_w(input int unsigned nch);
        return clog2(nch) + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

`endif

// File: rtl/trace_fifo.sv
// Event FIFO with a registered head word; a write into an empty FIFO lands
// directly in the head so it is visible the cycle after the write.
module trace_fifo import trace_pkg::*; #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DW-1:0]             wr_data,
    output logic                      full,
    input  logic                      rd_en,
    output logic [DW-1:0]             rd_data,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    head;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_nxt  = rd_ptr + 1'b1;
    assign rd_data = head;
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_nxt;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // head mirrors mem[rd_ptr]; the next entry is already in mem when cnt >= 2
            if (empty && do_wr) begin
                head <= wr_data;
            end else if (do_rd) begin
                if (cnt == CNT_W'(1)) begin
                    if (do_wr) head <= wr_data;
                end else begin
                    head <= mem[rd_nxt];
                end
            end
        end
    end

endmodule

// File: rtl/reg_trace_monitor.sv
// Logs value changes on NCH probe channels as {ts, channel, value} events in a FIFO.
// Optional TRACE_FILTER_EN adds the ch_mask port for per-channel event filtering.
module reg_trace_monitor import trace_pkg::*; #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TS_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NCH*WIDTH-1:0]      ch_data,
`ifdef TRACE_FILTER_EN
    input  logic [NCH-1:0]            ch_mask,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W-1:0]           out_ts,
    output logic [ch_w(NCH)-1:0]      out_ch,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      lost
);

    localparam int unsigned CH_W = ch_w(NCH);
    localparam int unsigned EV_W = TS_W + CH_W + WIDTH;

    trace_state_e state, state_nxt;
    logic                armed;
    logic [TS_W-1:0]     ts;
    logic [WIDTH-1:0]    prev    [NCH];
    logic [WIDTH-1:0]    cap_val [NCH];
    logic [TS_W-1:0]     cap_ts  [NCH];
    logic [NCH-1:0]      pend;
    logic [NCH-1:0]      chg;
    logic [NCH-1:0]      sel_oh;
    logic [NCH-1:0]      clr;
    logic [NCH-1:0]      trace_mask;
    logic [CH_W-1:0]     sel;
    logic [TS_W-1:0]     push_ts;
    logic [WIDTH-1:0]    push_val;
    logic                found;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [EV_W-1:0]     wr_ev;
    logic [EV_W-1:0]     rd_ev;

`ifdef TRACE_FILTER_EN
    assign trace_mask = ch_mask;
`else
    assign trace_mask = '1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // First enabled cycle only snapshots the baseline; events start the cycle after.
    always_comb begin
        state_nxt = en ? ST_ARMED : ST_IDLE;
    end

    always_comb begin
        armed = (state == ST_ARMED);
    end

    always_comb begin
        chg = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            chg[k] = en && armed && trace_mask[k] && (ch_data[k*WIDTH +: WIDTH] != prev[k]);
        end
    end

    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_oh   = '0;
        push_ts  = '0;
        push_val = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (pend[k] && !found) begin
                found     = 1'b1;
                sel       = CH_W'(k);
                sel_oh[k] = 1'b1;
                push_ts   = cap_ts[k];
                push_val  = cap_val[k];
            end
        end
    end

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = found && (!full || pop);
    assign clr       = push ? sel_oh : '0;
    assign wr_ev     = `TRACE_EV_PACK(push_ts, sel, push_val);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts   <= '0;
            pend <= '0;
            lost <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                prev[k]    <= '0;
                cap_val[k] <= '0;
                cap_ts[k]  <= '0;
            end
        end else begin
            if (en) ts <= ts + 1'b1;
            // a change landing on a slot being pushed this cycle re-arms it, nothing is lost
            pend <= chg | (pend & ~clr);
            if (|(chg & pend & ~clr)) lost <= 1'b1;
            for (int unsigned k = 0; k < NCH; k++) begin
                if (en) prev[k] <= ch_data[k*WIDTH +: WIDTH];
                if (chg[k]) begin
                    cap_val[k] <= ch_data[k*WIDTH +: WIDTH];
                    cap_ts[k]  <= ts;
                end
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .DW    (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_ev),
        .full    (full),
        .rd_en   (pop),
        .rd_data (rd_ev),
        .empty   (empty),
        .count   (count)
    );

    assign `TRACE_EV_FIELDS(out_ts, out_ch, out_data) = rd_ev;

endmodule

// File: tb/tb_reg_trace_monitor.sv
// Directed bench for reg_trace_monitor (NCH=2, WIDTH=32, DEPTH=4, TS_W=4).
module tb_reg_trace_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] ch0;
    logic [31:0] ch1;
    logic [63:0] ch_data;
`ifdef TRACE_FILTER_EN
    logic [1:0]  ch_mask;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ts;
    logic [1:0]  out_ch;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        lost;

    int errors;
    int checks;

    assign ch_data = {ch1, ch0};

    reg_trace_monitor #(
        .NCH   (2),
        .WIDTH (32),
        .DEPTH (4),
        .TS_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_data   (ch_data),
`ifdef TRACE_FILTER_EN
        .ch_mask   (ch_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .count     (count),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [1:0] ch, input logic [31:0] data,
                              input logic [3:0] ts);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_ch"},    64'(out_ch),    64'(ch));
        check({tag, "_data"},  64'(out_data),  64'(data));
        check({tag, "_ts"},    64'(out_ts),    64'(ts));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        en        = 1'b0;
        ch0       = '0;
        ch1       = '0;
        out_ready = 1'b0;
`ifdef TRACE_FILTER_EN
        ch_mask   = 2'b11;
`endif
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count),     64'd0);
        check("rst_lost",  64'(lost),      64'd0);
        check("rst_ts",    64'(out_ts),    64'd0);
        check("rst_ch",    64'(out_ch),    64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        rst = 1'b1;
        tick();

        // single change on ch0 while ts=3
        en = 1'b1;
        tick();
        tick();
        check("base_valid", 64'(out_valid), 64'd0);
        check("base_count", 64'(count),     64'd0);
        tick();
        ch0 = 32'h2A;
        tick();
        check("lat_valid", 64'(out_valid), 64'd0);
        tick();
        check_head("single", 2'd0, 32'h2A, 4'd3);
        check("single_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        check("single_pop_count", 64'(count),     64'd0);
        check("single_pop_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // simultaneous changes at ts=6
        ch0 = 32'd7;
        ch1 = 32'd9;
        tick();
        tick();
        check_head("sim0", 2'd0, 32'd7, 4'd6);
        check("sim0_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        check_head("sim1", 2'd1, 32'd9, 4'd6);
        tick();
        check("sim_drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // timestamp wrap: change at ts=15 then at ts=17 mod 16 = 1
        repeat (5) tick();
        ch0 = 32'h15;
        tick();
        tick();
        check_head("wrap0", 2'd0, 32'h15, 4'd15);
        ch0       = 32'h17;
        out_ready = 1'b1;
        tick();
        check("wrap_mid_count", 64'(count), 64'd0);
        tick();
        check_head("wrap1", 2'd0, 32'h17, 4'd1);
        tick();
        check("wrap_drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // backpressure: fill FIFO, accumulate pending, overwrite one
        ch0 = 32'h100; tick();
        ch1 = 32'h101; tick();
        ch0 = 32'h102; tick();
        ch1 = 32'h103; tick();
        ch0 = 32'h104; tick();
        ch1 = 32'h105; tick();
        check("full_count", 64'(count), 64'd4);
        check("full_lost",  64'(lost),  64'd0);
        check_head("full_head", 2'd0, 32'h100, 4'd4);
        ch0 = 32'h106;
        tick();
        check("ovw_lost",  64'(lost),  64'd1);
        check("ovw_count", 64'(count), 64'd4);
        check_head("ovw_stable", 2'd0, 32'h100, 4'd4);
        out_ready = 1'b1;
        tick();
        check_head("drain1", 2'd1, 32'h101, 4'd5);
        check("drain1_count", 64'(count), 64'd4);
        tick();
        check_head("drain2", 2'd0, 32'h102, 4'd6);
        check("drain2_count", 64'(count), 64'd4);
        tick();
        check_head("drain3", 2'd1, 32'h103, 4'd7);
        check("drain3_count", 64'(count), 64'd3);
        tick();
        check_head("drain4", 2'd0, 32'h106, 4'd10);
        tick();
        check_head("drain5", 2'd1, 32'h105, 4'd9);
        check("drain5_count", 64'(count), 64'd1);
        tick();
        check("drained_count", 64'(count),     64'd0);
        check("drained_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // reset with 4 queued plus 1 pending
        ch0 = 32'd1; tick();
        ch1 = 32'd2; tick();
        ch0 = 32'd3; tick();
        ch1 = 32'd4; tick();
        ch0 = 32'd5; tick();
        check("prerst_count", 64'(count), 64'd4);
        check("prerst_lost",  64'(lost),  64'd1);
        rst = 1'b0;
        tick();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(count),     64'd0);
        check("midrst_lost",  64'(lost),      64'd0);
        check("midrst_data",  64'(out_data),  64'd0);
        check("midrst_ts",    64'(out_ts),    64'd0);
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("rebase_valid", 64'(out_valid), 64'd0);
        check("rebase_count", 64'(count),     64'd0);
        ch1 = 32'h55;
        tick();
        tick();
        check_head("postrst", 2'd1, 32'h55, 4'd3);
        check("postrst_count", 64'(count), 64'd1);

        // disabled: changes ignored
        out_ready = 1'b1;
        en        = 1'b0;
        ch0       = 32'h99;
        tick();
        check("dis_count", 64'(count), 64'd0);
        tick();
        check("dis_valid", 64'(out_valid), 64'd0);
        check("dis_count2", 64'(count),    64'd0);
        out_ready = 1'b0;

`ifdef TRACE_FILTER_EN
        en = 1'b1;
        tick();
        ch_mask = 2'b10;
        ch0     = 32'hA0;
        ch1     = 32'hA1;
        tick();
        tick();
        check_head("mask", 2'd1, 32'hA1, 4'd6);
        check("mask_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        tick();
        check("mask_pop_count", 64'(count), 64'd0);
        out_ready = 1'b0;
        ch_mask   = 2'b11;
        tick();
        tick();
        check("unmask_valid", 64'(out_valid), 64'd0);
        check("unmask_count", 64'(count),     64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
